ipu_rr_splitter: RTL
====================

# ipu_rr_splitter

Clocked, parametrised successor to the input-processing front end. Buffers packets from `NUM_IN` network input ports plus one local core port, arbitrates them round-robin into a single registered output stage, and splits each packet into address and payload fields for the router's address decoder and Hamming encoder. One instance sits between the node's network ingress links and the routing/ECC stage.

## Interface

Parameters:

- `NUM_IN`, 4: number of network input ports (≥2); the core port is source index `NUM_IN`.
- `ADDR_W`, 7: address field width (packet MSBs).
- `DATA_W`, 4: payload field width (packet LSBs).
- `FIFO_DEPTH`, 2: entries per source FIFO; power of two, ≥2.
- `PKT_W` (derived), `ADDR_W+DATA_W` (11).
- `SRC_W` (derived), `$clog2(NUM_IN+1)`.

Ports:

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  `NUM_IN`  per-port packet valid.
- `in_ready`  out  `NUM_IN`  per-port FIFO can accept.
- `in_pkt`  in  `NUM_IN*PKT_W`  packed packets; port i is `[i*PKT_W +: PKT_W]`.
- `core_valid`  in  1  core packet valid.
- `core_ready`  out  1  core FIFO can accept.
- `core_pkt`  in  `PKT_W`  core packet.
- `out_valid`  out  1  output register holds a packet.
- `out_ready`  in  1  downstream accepts.
- `out_addr`  out  `ADDR_W`  `pkt[PKT_W-1:DATA_W]`.
- `out_data`  out  `DATA_W`  `pkt[DATA_W-1:0]`.
- `out_src`  out  `SRC_W`  winning source index (0..`NUM_IN`).

## Operation

- Per-source FIFO (`NUM_IN+1` of them): push when `valid && ready`; pop on grant. FIFO order is preserved per source.
- `in_ready[i]` and `core_ready` are registered: they are 1 iff the FIFO is not full after this cycle's push/pop.
- Grant is issued in a cycle when at least one FIFO is non-empty and the output register is empty or draining (`out_valid && out_ready`). The granted head is loaded into `out_*` and `out_valid` is set. With no grant and a drain, `out_valid` clears.
- Round-robin: `rr_ptr` ranges over 0..`NUM_IN`. The search runs from `rr_ptr` upward with wrap. After a grant to source k, `rr_ptr <= (k+1) mod (NUM_IN+1)`. With no grant, `rr_ptr` holds.
- Split: pure bit-slice of the granted packet; no arithmetic is applied.
- Stall: while `out_valid && !out_ready`, all `out_*` values are stable and no grant occurs.

## Timing

- Reset (asynchronous assert): FIFOs empty, `rr_ptr`=0, `out_valid`=0, `out_addr`/`out_data`/`out_src`=0, `in_ready`=0, `core_ready`=0.
- `in_ready`/`core_ready` rise on the first `clk` edge after `rst_n` deasserts.
- Latency: a packet pushed at edge N is visible to the arbiter in cycle N+1, is loaded at edge N+1, and shows `out_valid`=1 after edge N+1. Minimum is 2 edges from acceptance to output.
- There is no FIFO bypass. A push into an empty FIFO cannot be granted in the same cycle.
- Full FIFO with a simultaneous pop: `ready` was 0 at the cycle start, so there is no push. `ready` rises at the next edge.
- Throughput: 1 packet/cycle when `out_ready` is held at 1.
- Reset mid-operation: all buffered and in-flight packets are discarded, with no partial output.

## Configuration

- `IPU_CORE_PRIORITY_EN` defined: a non-empty core FIFO always wins over network sources. `rr_ptr` is not updated on a core grant. Network sources round-robin among `0..NUM_IN-1` when the core FIFO is empty.
- Not defined: the core is an ordinary round-robin participant at index `NUM_IN`.

## Test plan

- Reset: assert `rst_n`=0 mid-traffic → `out_valid`=0 and all ready signals 0 immediately. Release → ready signals all 1 after the first edge, and no stale packet is emitted.
- Single packet: `in_pkt[0]`=11'h5A3, one-cycle valid, `out_ready`=1 → 2 edges later `out_valid`=1, `out_addr`=7'h5A, `out_data`=4'h3, `out_src`=0, held for exactly one cycle.
- Fairness, macro off: all 4 inputs and the core continuously valid, `out_ready`=1 → `out_src` sequence 0,1,2,3,4,0,1… with no gaps.
- Core priority, macro on: same stimulus → `out_src`=4 every cycle while the core FIFO is non-empty. Stop the core → 0,1,2,3 resumes from the saved `rr_ptr`.
- Backpressure: `out_ready`=0, port 1 offers packets 11'h001,11'h002,11'h003,11'h004 → 3 are accepted (2 in FIFO, 1 in the output register) and `in_ready[1]`=0. Then `out_ready`=1 → output 001,002,003,004 in order, with no loss or duplication.
- Wrap/sparse: `NUM_IN`=3, only ports 2 and 0 valid, starting from `rr_ptr`=0 → `out_src` 0,2,0,2…, confirming the pointer wraps past idle sources 1 and 3.

Source files
------------

// File: rtl/ipu_rr_splitter_if.sv
// ipu_rr_splitter_if
//   Handshake bundle between network/core ingress, the ipu_rr_splitter
//   front end and the downstream address-decode / Hamming stage.
//   Ports carried:
//     in_valid/in_ready/in_pkt     NUM_IN network ports; port i is
//                                  in_pkt[i*PKT_W +: PKT_W]
//     core_valid/core_ready/core_pkt  local core port
//     out_valid/out_ready          registered output handshake
//     out_addr/out_data/out_src    split packet fields and winning source
//   Modports: master = upstream/downstream environment, slave = splitter.
interface ipu_rr_splitter_if #(
    parameter int NUM_IN = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 4
);
    localparam int PKT_W = ADDR_W + DATA_W;
    localparam int SRC_W = $clog2(NUM_IN + 1);

    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [NUM_IN*PKT_W-1:0] in_pkt;
    logic                    core_valid;
    logic                    core_ready;
    logic [PKT_W-1:0]        core_pkt;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_W-1:0]       out_addr;
    logic [DATA_W-1:0]       out_data;
    logic [SRC_W-1:0]        out_src;

    modport master (
        output in_valid, in_pkt, core_valid, core_pkt, out_ready,
        input  in_ready, core_ready, out_valid, out_addr, out_data, out_src
    );

    modport slave (
        input  in_valid, in_pkt, core_valid, core_pkt, out_ready,
        output in_ready, core_ready, out_valid, out_addr, out_data, out_src
    );
endinterface

// File: rtl/ipu_rr_splitter.sv
// ipu_rr_splitter
//   Buffers packets from NUM_IN network ports plus the local core port in
//   one FIFO per source, arbitrates the FIFO heads round-robin into a single
//   registered output stage and splits each packet into address (MSBs) and
//   payload (LSBs).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    ipu_rr_splitter_if.slave (ingress handshakes, output stage)
//   Optional feature macro: IPU_CORE_PRIORITY_EN
//     defined   - a non-empty core FIFO always wins; network ports share
//                 round-robin over 0..NUM_IN-1 and rr_ptr is untouched by
//                 core grants.
//     undefined - the core is an ordinary round-robin source at NUM_IN.
module ipu_rr_splitter #(
    parameter int NUM_IN     = 4,
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input logic             clk,
    input logic             rst_n,
    ipu_rr_splitter_if.slave bus
);
    localparam int PKT_W = ADDR_W + DATA_W;
    localparam int SRC_W = $clog2(NUM_IN + 1);
    localparam int NSRC  = NUM_IN + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef IPU_CORE_PRIORITY_EN
    localparam int unsigned RR_LAST = NUM_IN - 1;
`else
    localparam int unsigned RR_LAST = NUM_IN;
`endif

    logic [PKT_W-1:0] mem    [NSRC][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [NSRC];
    logic [PTR_W-1:0] rd_ptr [NSRC];
    logic [CNT_W-1:0] cnt    [NSRC];
    logic [CNT_W-1:0] cnt_next [NSRC];
    logic [PKT_W-1:0] head   [NSRC];
    logic [PKT_W-1:0] src_pkt[NSRC];

    logic [NSRC-1:0]  src_valid;
    logic [NSRC-1:0]  src_ready;
    logic [NSRC-1:0]  push;
    logic [NSRC-1:0]  pop;
    logic [NSRC-1:0]  nonempty;

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_next;
    logic             gnt_any;
    logic             gnt_fire;
    logic [SRC_W-1:0] gnt_idx;
    logic [PKT_W-1:0] gnt_pkt;
    logic             search_en;
    int unsigned      cand;

    logic              out_valid_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SRC_W-1:0]  out_src_q;

    assign src_valid      = {bus.core_valid, bus.in_valid};
    assign bus.in_ready   = src_ready[NUM_IN-1:0];
    assign bus.core_ready = src_ready[NUM_IN];
    assign bus.out_valid  = out_valid_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;

    always_comb begin
        for (int unsigned s = 0; s < NUM_IN; s++) begin
            src_pkt[s] = bus.in_pkt[s*PKT_W +: PKT_W];
        end
        src_pkt[NUM_IN] = bus.core_pkt;
    end

    always_comb begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            head[s]     = mem[s][rd_ptr[s]];
            nonempty[s] = (cnt[s] != '0);
        end
    end

    // Search from rr_ptr upward with wrap; first non-empty source wins.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        gnt_pkt   = '0;
        search_en = 1'b1;
        cand      = 0;
`ifdef IPU_CORE_PRIORITY_EN
        if (nonempty[NUM_IN]) begin
            gnt_any   = 1'b1;
            gnt_idx   = SRC_W'(NUM_IN);
            gnt_pkt   = head[NUM_IN];
            search_en = 1'b0;
        end
`endif
        if (search_en) begin
            for (int unsigned off = 0; off <= RR_LAST; off++) begin
                cand = 32'(rr_ptr) + off;
                if (cand > RR_LAST) cand = cand - (RR_LAST + 1);
                if (!gnt_any && nonempty[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SRC_W'(cand);
                    gnt_pkt = head[cand];
                end
            end
        end
    end

    // Grant only when the output register is empty or draining this cycle.
    assign gnt_fire = gnt_any && (!out_valid_q || bus.out_ready);
    assign rr_next  = (gnt_idx == SRC_W'(RR_LAST)) ? '0 : gnt_idx + SRC_W'(1);

    always_comb begin
        push = src_valid & src_ready;
        pop  = '0;
        if (gnt_fire) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                if (gnt_idx == SRC_W'(s)) pop[s] = 1'b1;
            end
        end
        for (int unsigned s = 0; s < NSRC; s++) begin
            cnt_next[s] = cnt[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NSRC; s++) begin
            if (push[s]) mem[s][wr_ptr[s]] <= src_pkt[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            src_ready   <= '0;
            rr_ptr      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            for (int unsigned s = 0; s < NSRC; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                cnt[s]       <= cnt_next[s];
                src_ready[s] <= (cnt_next[s] != CNT_W'(FIFO_DEPTH));
            end
            if (gnt_fire) begin
                out_valid_q <= 1'b1;
                out_addr_q  <= gnt_pkt[PKT_W-1:DATA_W];
                out_data_q  <= gnt_pkt[DATA_W-1:0];
                out_src_q   <= gnt_idx;
`ifdef IPU_CORE_PRIORITY_EN
                if (gnt_idx != SRC_W'(NUM_IN)) rr_ptr <= rr_next;
`else
                rr_ptr <= rr_next;
`endif
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule
